// File: rtl/hamming_pkg.sv
// Shared constants and elaboration-time helpers for the extended-Hamming (SECDED) codec.
package hamming_pkg;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

    // Smallest P with 2^P >= K+P+1.
    function automatic int calc_p(input int k);
        int r;
        r = 30;
        for (int p = 30; p >= 1; p--) begin
            if ((1 << p) >= k + p + 1) r = p;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data bit index carried by a non-power-of-two Hamming position.
    function automatic int data_idx(input int pos);
        return pos - $clog2(pos + 1) - 1;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity unit over Hamming positions 1..N,
// shared by the encode and decode paths.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int N = 7,
    parameter int P = 3
) (
    input  logic [N:1]   pos,
    output logic [P-1:0] syn,
    output logic         par
);

    always_comb begin
        syn = '0;
        for (int i = 1; i <= N; i++) begin
            if (pos[i]) syn = syn ^ P'(i);
        end
    end

    assign par = ^pos;

endmodule

// File: rtl/hamming_secded_stream.sv
// Two-stage valid/ready SECDED encoder/decoder with saturating error counters.
// Optional macro HAMMING_ERR_INJECT_EN adds inj_en/inj_pos single-bit injection on encode.
module hamming_secded_stream
    import hamming_pkg::*;
#(
    parameter  int K     = 4,
    parameter  int CNT_W = 8,
    localparam int P     = calc_p(K),
    localparam int N     = K + P,
    localparam int CW    = N + 1
`ifdef HAMMING_ERR_INJECT_EN
    ,
    localparam int IW    = $clog2(CW)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [CW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_data,
    output logic [1:0]       out_err,
    input  logic             cnt_clr,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic             inj_en,
    input  logic [IW-1:0]    inj_pos,
`endif
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             en;
    logic             vld_p1;
    logic             vld_p2;
    logic             mode_p1;
    logic [K-1:0]     dat_p1;
    logic [P-1:0]     syn_p1;
    logic             q_p1;
    logic [CW-1:0]    inj_mask_p1;

    logic [N:1]       syn_in;
    logic [K-1:0]     gath;
    logic [K-1:0]     dat_in;
    logic [P-1:0]     syn;
    logic             par;

    logic [CW-1:0]    enc_cw;
    logic [K-1:0]     flip_mask;
    logic [K-1:0]     dec_k;
    logic             flip;
    logic [1:0]       err_calc;
    logic [CW-1:0]    res;
    logic             hs;

    assign en        = !vld_p2 || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;

    // Stage 0: encode feeds data with parity positions zeroed; decode feeds the codeword.
    for (genvar i = 1; i <= N; i++) begin : g_pos
        if (is_pow2(i)) begin : g_par
            assign syn_in[i] = in_mode & in_data[i];
            assign enc_cw[i] = syn_p1[$clog2(i)];
        end else begin : g_dat
            assign gath[data_idx(i)]      = in_data[i];
            assign syn_in[i]              = in_mode ? in_data[i] : in_data[data_idx(i)];
            assign enc_cw[i]              = dat_p1[data_idx(i)];
            assign flip_mask[data_idx(i)] = flip && (syn_p1 == P'(i));
        end
    end

    hamming_syndrome #(.N(N), .P(P)) u_syn (
        .pos (syn_in),
        .syn (syn),
        .par (par)
    );

    assign dat_in = in_mode ? gath : in_data[K-1:0];

    // Stage 1: mode, raw data bits, syndrome and overall parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            mode_p1 <= in_mode;
            dat_p1  <= dat_in;
            syn_p1  <= syn;
            q_p1    <= par ^ (in_mode & in_data[0]);
        end
    end

`ifdef HAMMING_ERR_INJECT_EN
    logic [CW-1:0] inj_mask;

    always_comb begin
        inj_mask = '0;
        if (inj_en && !in_mode && (32'(inj_pos) < CW)) inj_mask = CW'(1) << inj_pos;
    end

    always_ff @(posedge clk) begin
        if (en && in_valid) inj_mask_p1 <= inj_mask;
    end
`else
    assign inj_mask_p1 = '0;
`endif

    // Overall parity of the encoded word: data-position parity plus the parity bits.
    assign enc_cw[0] = q_p1 ^ (^syn_p1);
    assign flip      = q_p1 && (32'(syn_p1) <= N);
    assign dec_k     = dat_p1 ^ flip_mask;

    always_comb begin
        err_calc = ERR_NONE;
        if (mode_p1) begin
            if (!q_p1 && (syn_p1 == '0)) err_calc = ERR_NONE;
            else if (flip)               err_calc = ERR_CORR;
            else                         err_calc = ERR_UNCORR;
        end
    end

    assign res = mode_p1 ? CW'(dec_k) : (enc_cw ^ inj_mask_p1);

    // Stage 2: registered result and error class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_err  <= ERR_NONE;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data <= res;
                out_err  <= err_calc;
            end
        end
    end

    assign hs = vld_p2 && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (hs) begin
            if (out_err == ERR_CORR)   corr_cnt   <= sat_inc(corr_cnt);
            if (out_err == ERR_UNCORR) uncorr_cnt <= sat_inc(uncorr_cnt);
        end
    end

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Scoreboard bench for hamming_secded_stream at K=4 (CW=8), CNT_W=2.
module tb_hamming_secded_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_err;
    logic       cnt_clr;
    logic [1:0] corr_cnt;
    logic [1:0] uncorr_cnt;
`ifdef HAMMING_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] held_d;
    logic [1:0] held_e;

    hamming_secded_stream #(.K(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .cnt_clr    (cnt_clr),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
`endif
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference (7,4)+overall-parity encoder written from the bit layout.
    function automatic logic [7:0] enc4(input logic [3:0] d);
        logic       p1, p2, p4;
        logic [6:0] hi;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        hi = {d[3], d[2], d[1], p4, d[0], p2, p1};
        return {hi, ^hi};
    endfunction

    function automatic logic [7:0] dat4(input logic [7:0] cw);
        return {4'b0, cw[7], cw[6], cw[5], cw[3]};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.data));
                chk("out_err", 32'(out_err), 32'(mon_e.err));
            end
        end
    end

    task automatic send(input logic mode, input logic [7:0] data,
                        input logic [7:0] ed, input logic [1:0] ee);
        int waitc;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'(1));
        sb.push_back({ed, ee});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("drain_left", 32'(sb.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cw;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en    = 1'b0;
        inj_pos   = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_err", 32'(out_err), 32'(0));
        chk("rst_corr", 32'(corr_cnt), 32'(0));
        chk("rst_uncorr", 32'(uncorr_cnt), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'(1));

        send(1'b0, 8'h0B, 8'hAA, 2'b00);
        chk("lat1_cycle1", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        chk("lat1_cycle2", 32'(out_valid), 32'(1));
        drain();
        send(1'b1, 8'hAA, 8'h0B, 2'b00);
        drain();
        send(1'b1, 8'h8A, 8'h0B, 2'b01);
        drain();
        chk("corr_1", 32'(corr_cnt), 32'(1));
        send(1'b1, 8'hAB, 8'h0B, 2'b01);
        drain();
        chk("corr_2", 32'(corr_cnt), 32'(2));
        send(1'b1, 8'h88, 8'h09, 2'b10);
        drain();
        chk("uncorr_1", 32'(uncorr_cnt), 32'(1));
        for (int i = 2; i <= 6; i++) send(1'b1, 8'hAA ^ (8'h01 << i), 8'h0B, 2'b01);
        drain();
        chk("corr_sat", 32'(corr_cnt), 32'(3));

        // All data values: encode with junk upper bits, one single-error and one double-error decode.
        for (int d = 0; d < 16; d++) begin
            cw = enc4(4'(d));
            send(1'b0, {4'(15 - d), 4'(d)}, cw, 2'b00);
            send(1'b1, cw ^ (8'h01 << (d % 8)), 8'(d), 2'b01);
            send(1'b1, cw ^ 8'h48, dat4(cw ^ 8'h48), 2'b10);
        end
        drain();
        chk("uncorr_sat", 32'(uncorr_cnt), 32'(3));

        send(1'b1, 8'hAE, 8'h0B, 2'b01);
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_wins_corr", 32'(corr_cnt), 32'(0));
        chk("clr_uncorr", 32'(uncorr_cnt), 32'(0));
        drain();

        fork
            begin
                send(1'b0, 8'h05, enc4(4'h5), 2'b00);
                send(1'b1, 8'h88, 8'h09, 2'b10);
                send(1'b0, 8'h0F, 8'hFF, 2'b00);
                send(1'b1, 8'h8A, 8'h0B, 2'b01);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                held_d = out_data;
                held_e = out_err;
                chk("stall_valid", 32'(out_valid), 32'(1));
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'(0));
                    chk("stall_hold_data", 32'(out_data), 32'(held_d));
                    chk("stall_hold_err", 32'(out_err), 32'(held_e));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_corr", 32'(corr_cnt), 32'(1));
        chk("stream_uncorr", 32'(uncorr_cnt), 32'(1));

        send(1'b1, 8'h88, 8'h09, 2'b10);
        send(1'b1, 8'h8A, 8'h0B, 2'b01);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_data", 32'(out_data), 32'(0));
        chk("midrst_corr", 32'(corr_cnt), 32'(0));
        chk("midrst_uncorr", 32'(uncorr_cnt), 32'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("postrst_valid", 32'(out_valid), 32'(0));
        send(1'b0, 8'h05, enc4(4'h5), 2'b00);
        chk("lat2_cycle1", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        chk("lat2_cycle2", 32'(out_valid), 32'(1));
        drain();

`ifdef HAMMING_ERR_INJECT_EN
        inj_en  = 1'b1;
        inj_pos = 3'd3;
        send(1'b0, 8'h0B, 8'hA2, 2'b00);
        send(1'b1, 8'hAA, 8'h0B, 2'b00);
        inj_en  = 1'b0;
        send(1'b1, 8'hA2, 8'h0B, 2'b01);
        send(1'b0, 8'h0B, 8'hAA, 2'b00);
        drain();
`endif

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
